// File: rtl/r_arbiter.sv
// Round-robin arbiter sharing the async FIFO read port between NUM_REQ consumers.
// Each grant pops at most BURST_MAX words; optional bubble after every pop.
module r_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int BURST_MAX  = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BACK2BACK  = 0
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic [NUM_REQ-1:0]    req,
    input  logic                  rempty,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  ren,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [NUM_REQ-1:0]    pop_vld,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  busy
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(BURST_MAX + 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t             state_r;
    logic [NUM_REQ-1:0] gnt_r;
    logic [IDX_W-1:0]   rr_ptr_r;
    logic [IDX_W-1:0]   g_idx_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               bubble_r;

    logic               found_s;
    logic [IDX_W-1:0]   pick_s;
    int                 idx_s;
    logic               ren_s;
    logic               exit_s;
    logic [IDX_W-1:0]   next_ptr_s;

    // Round-robin search for the first active request starting at rr_ptr.
    always_comb begin
        found_s = 1'b0;
        pick_s  = '0;
        idx_s   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_s = (int'(rr_ptr_r) + k) % NUM_REQ;
            if (!found_s && req[idx_s]) begin
                found_s = 1'b1;
                pick_s  = IDX_W'(idx_s);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Pop qualification, burst termination and next round-robin start point.
    always_comb begin
        ren_s  = (state_r == BURST) && req[g_idx_r] && !rempty && !bubble_r;
        // A bubble cycle with data still present keeps the burst alive.
        exit_s = (ren_s && (cnt_r == CNT_W'(BURST_MAX - 1)))
               || !req[g_idx_r]
               || (rempty && !ren_s);
        if (g_idx_r == IDX_W'(NUM_REQ - 1)) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = g_idx_r + IDX_W'(1);
        end
    end

    // Arbiter state machine with grant, pointer, burst count and bubble registers.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            state_r  <= IDLE;
            gnt_r    <= '0;
            rr_ptr_r <= '0;
            g_idx_r  <= '0;
            cnt_r    <= '0;
            bubble_r <= 1'b0;
        end else begin
            bubble_r <= (BACK2BACK != 0) ? 1'b0 : ren_s;
            case (state_r)
                IDLE: begin
                    if (found_s && !rempty) begin
                        gnt_r   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_s;
                        g_idx_r <= pick_s;
                        cnt_r   <= '0;
                        state_r <= BURST;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BURST: begin
                    if (exit_s) begin
                        state_r  <= IDLE;
                        gnt_r    <= '0;
                        cnt_r    <= '0;
                        rr_ptr_r <= next_ptr_s;
                    end else if (ren_s) begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    gnt_r   <= '0;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

    assign ren     = ren_s;
    assign gnt     = gnt_r;
    assign pop_vld = gnt_r & {NUM_REQ{ren_s}};
    assign dout    = rdata;
    assign busy    = (state_r == BURST);

endmodule

// File: tb/tb_r_arbiter.sv
// Directed bench for r_arbiter: one instance with pop bubbles, one back-to-back,
// driven by a shared word-counting FIFO model.
module tb_r_arbiter;
    logic       rclk;
    logic       rrst;
    logic [3:0] req;
    logic       rempty;
    logic [7:0] rdata;

    logic       ren_a, busy_a, ren_b, busy_b;
    logic [3:0] gnt_a, pop_a, gnt_b, pop_b;
    logic [7:0] dout_a, dout_b;

    logic       sel;
    int         words;
    int         popped;
    int         vectors;
    int         fails;
    logic [7:0] pat;

    r_arbiter #(.NUM_REQ(4), .BURST_MAX(4), .DATA_WIDTH(8), .BACK2BACK(0)) u_a (
        .rclk(rclk), .rrst(rrst), .req(req), .rempty(rempty), .rdata(rdata),
        .ren(ren_a), .gnt(gnt_a), .pop_vld(pop_a), .dout(dout_a), .busy(busy_a)
    );

    r_arbiter #(.NUM_REQ(4), .BURST_MAX(4), .DATA_WIDTH(8), .BACK2BACK(1)) u_b (
        .rclk(rclk), .rrst(rrst), .req(req), .rempty(rempty), .rdata(rdata),
        .ren(ren_b), .gnt(gnt_b), .pop_vld(pop_b), .dout(dout_b), .busy(busy_b)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; the FIFO model pops when the selected instance enabled a read.
    task automatic cyc();
        logic pre;
        pre = sel ? ren_b : ren_a;
        @(posedge rclk);
        #1;
        if (pre === 1'b1 && words > 0) begin
            words--;
            popped++;
        end
        rempty = (words == 0);
        rdata  = 8'h40 + 8'(popped);
        #1;
    endtask

    task automatic fill(input int n);
        words  = n;
        popped = 0;
        rempty = (n == 0);
        rdata  = 8'h40;
        #1;
    endtask

    task automatic do_reset(input int n);
        rrst = 1'b1;
        cyc();
        cyc();
        rrst = 1'b0;
        fill(n);
    endtask

    initial begin
        vectors = 0;
        fails   = 0;
        sel     = 1'b0;
        rrst    = 1'b1;
        req     = 4'hF;
        words   = 16;
        popped  = 0;
        rempty  = 1'b0;
        rdata   = 8'h40;

        // Reset held with all requests and data present
        cyc();
        for (int i = 0; i < 3; i++) begin
            chk("rst_ren", ren_a, 1'b0);
            chk("rst_gnt", gnt_a, 4'b0000);
            chk("rst_busy", busy_a, 1'b0);
            cyc();
        end
        rrst = 1'b0;
        #1;
        chk("rel_idle_gnt", gnt_a, 4'b0000);
        chk("rel_idle_ren", ren_a, 1'b0);
        cyc();
        chk("rel_gnt", gnt_a, 4'b0001);
        chk("rel_busy", busy_a, 1'b1);

        // Back-to-back: four grants of four pops, one idle cycle between
        sel = 1'b1;
        req = 4'hF;
        do_reset(16);
        chk("b2b_idle0", gnt_b, 4'b0000);
        for (int g = 0; g < 4; g++) begin
            for (int p = 0; p < 4; p++) begin
                cyc();
                chk("b2b_gnt", gnt_b, 4'b0001 << g);
                chk("b2b_ren", ren_b, 1'b1);
                chk("b2b_pop", pop_b, 4'b0001 << g);
                chk("b2b_dout", dout_b, 8'h40 + 8'(popped));
            end
            cyc();
            chk("b2b_gap_gnt", gnt_b, 4'b0000);
            chk("b2b_gap_ren", ren_b, 1'b0);
        end
        chk("b2b_total", popped, 16);
        chk("b2b_empty", rempty, 1'b1);

        // Bubble mode, single requester, three words
        sel = 1'b0;
        req = 4'b0100;
        do_reset(3);
        pat = 8'b0001_0101;
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk("bub_ren", ren_a, pat[i]);
            chk("bub_pop", pop_a, pat[i] ? 4'b0100 : 4'b0000);
        end
        chk("bub_count", popped, 3);
        chk("bub_end_gnt", gnt_a, 4'b0000);

        // Grantee 1 drops its request after two pops
        sel = 1'b1;
        req = 4'b1010;
        do_reset(16);
        cyc();
        chk("drop_gnt1", gnt_b, 4'b0010);
        chk("drop_ren1", ren_b, 1'b1);
        cyc();
        chk("drop_ren2", ren_b, 1'b1);
        cyc();
        req = 4'b1000;
        #1;
        chk("drop_noren", ren_b, 1'b0);
        chk("drop_nopop", pop_b, 4'b0000);
        chk("drop_gnt_hold", gnt_b, 4'b0010);
        cyc();
        chk("drop_idle", gnt_b, 4'b0000);
        for (int p = 0; p < 4; p++) begin
            cyc();
            chk("drop_gnt3", gnt_b, 4'b1000);
            chk("drop_ren3", ren_b, 1'b1);
        end
        cyc();
        chk("drop_end", gnt_b, 4'b0000);
        chk("drop_count", popped, 6);

        // Empty FIFO keeps the arbiter idle
        sel = 1'b0;
        req = 4'hF;
        do_reset(0);
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("empty_gnt", gnt_a, 4'b0000);
            chk("empty_busy", busy_a, 1'b0);
        end
        fill(5);
        chk("fill_gnt_same", gnt_a, 4'b0000);
        cyc();
        chk("fill_gnt", gnt_a, 4'b0001);
        chk("fill_busy", busy_a, 1'b1);

        // Reset in the middle of a burst
        chk("mid_ren_a", ren_a, 1'b1);
        cyc();
        chk("mid_ren_b", ren_a, 1'b0);
        cyc();
        chk("mid_ren_c", ren_a, 1'b1);
        cyc();
        rrst = 1'b1;
        #1;
        cyc();
        rrst = 1'b0;
        #1;
        chk("mid_rst_gnt", gnt_a, 4'b0000);
        chk("mid_rst_ren", ren_a, 1'b0);
        chk("mid_rst_busy", busy_a, 1'b0);
        cyc();
        chk("mid_regnt", gnt_a, 4'b0001);
        chk("mid_words", words, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
